// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared opcodes, ALU/operand codes, FSM state encoding and the
//             control-word layout for the multi-cycle MIPS-subset control unit.
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Opcodes taken from IR[31:26]
    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] BEQ    = 6'b000100;

    // ALU operation select
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // FSM encoding; values 11..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        R_WB      = 4'd7,
        EXEC_I    = 4'd8,
        I_WB      = 4'd9,
        BRANCH    = 4'd10
    } state_t;

    // Full control word produced by the output decoder
    typedef struct packed {
        logic       pc_en;
        logic       ir_en;
        logic       iord;
        logic       enr;
        logic       enw;
        logic       br_en;
        logic       reg_dest;
        logic       mux1;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_c;
        logic       pc_src;
        logic       instr_done;
    } ctrl_t;

    // True for every opcode this control unit knows how to sequence
    function automatic logic is_supported(input logic [5:0] op);
        return (op == R_TYPE) || (op == ADDI) || (op == LW) ||
               (op == SW)     || (op == BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_multiciclo_if.sv
`default_nettype none
// ============================================================================
//  Module   : control_multiciclo_if
//  Purpose  : Bundle between the control unit (master) and the datapath/IR/
//             memory side (slave): status inputs and all control strobes.
//  Revision : 1.0  initial release
// ============================================================================
interface control_multiciclo_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;

    logic       PC_En;
    logic       IR_En;
    logic       IorD;
    logic       EnR;
    logic       EnW;
    logic       BR_En;
    logic       regDest;
    logic       Mux1;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [2:0] AluC;
    logic       PCSrc;
    logic       Instr_Done;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Opcode, Zero, MemReady,
        output PC_En, IR_En, IorD, EnR, EnW, BR_En, regDest, Mux1,
               AluSrcA, AluSrcB, AluC, PCSrc, Instr_Done, Illegal, State
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PC_En, IR_En, IorD, EnR, EnW, BR_En, regDest, Mux1,
               AluSrcA, AluSrcB, AluC, PCSrc, Instr_Done, Illegal, State
    );
endinterface
`default_nettype wire

// File: rtl/control_multiciclo_uc_salidas.sv
`default_nettype none
// ============================================================================
//  Module   : uc_salidas
//  Purpose  : Combinational control-word decoder. Moore outputs come from the
//             state alone; PC_En/IR_En/Instr_Done also follow Zero, MemReady
//             and the decode-time illegal-opcode indication.
//  Revision : 1.0  initial release
// ============================================================================
module uc_salidas
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    input  logic   mem_ready,
    input  logic   illegal_op,
    output ctrl_t  ctrl
);

    // Per-state control word; everything not named for a state stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.enr       = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_c     = ALU_ADD;
                ctrl.ir_en     = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            DECODE: begin
                // Branch target is computed here, before the opcode is known
                ctrl.alu_src_a  = 1'b0;
                ctrl.alu_src_b  = SRCB_IMM_SH2;
                ctrl.alu_c      = ALU_ADD;
                ctrl.instr_done = illegal_op;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_c     = ALU_ADD;
            end
            MEM_READ: begin
                ctrl.enr  = 1'b1;
                ctrl.iord = 1'b1;
            end
            MEM_WB: begin
                ctrl.br_en      = 1'b1;
                ctrl.mux1       = 1'b1;
                ctrl.reg_dest   = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.enw        = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_c     = ALU_FUNCT;
            end
            R_WB: begin
                ctrl.br_en      = 1'b1;
                ctrl.reg_dest   = 1'b1;
                ctrl.mux1       = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_c     = ALU_ADD;
            end
            I_WB: begin
                ctrl.br_en      = 1'b1;
                ctrl.reg_dest   = 1'b0;
                ctrl.mux1       = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_c      = ALU_SUB;
                ctrl.pc_src     = 1'b1;
                ctrl.pc_en      = zero;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : control_multiciclo
//  Purpose  : Multi-cycle control unit for the R-type/ADDI/LW/SW/BEQ subset.
//             Holds the state register, next-state logic and the sticky
//             Illegal flag; output decoding lives in uc_salidas.
//  Revision : 1.0  initial release
// ============================================================================
module control_multiciclo
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    control_multiciclo_if.master bus
);

    state_t state;
    state_t next_state;
    logic   illegal;
    logic   illegal_op;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;

    // Unsupported opcode seen while decoding
    assign illegal_op = (state == DECODE) && !is_supported(bus.Opcode);

    // State register; reset lands in FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (illegal_op) begin
            illegal <= 1'b1;
        end
    end

    // Next-state logic; MemReady only matters in the three memory states
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:     next_state = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Opcode)
                    R_TYPE:  next_state = EXEC_R;
                    ADDI:    next_state = EXEC_I;
                    LW, SW:  next_state = MEM_ADDR;
                    BEQ:     next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEM_ADDR:  next_state = (bus.Opcode == LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  next_state = bus.MemReady ? MEM_WB : MEM_READ;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: next_state = bus.MemReady ? FETCH : MEM_WRITE;
            EXEC_R:    next_state = R_WB;
            R_WB:      next_state = FETCH;
            EXEC_I:    next_state = I_WB;
            I_WB:      next_state = FETCH;
            BRANCH:    next_state = FETCH;
            default:   next_state = FETCH;
        endcase
    end

    uc_salidas u_salidas (
        .state      (state),
        .zero       (bus.Zero),
        .mem_ready  (bus.MemReady),
        .illegal_op (illegal_op),
        .ctrl       (ctrl)
    );

    // Force every strobe low while reset is held so nothing leaks mid-reset
    always_comb begin
        ctrl_gated = ctrl;
        if (rst) begin
            ctrl_gated = '0;
        end
    end

    assign bus.PC_En      = ctrl_gated.pc_en;
    assign bus.IR_En      = ctrl_gated.ir_en;
    assign bus.IorD       = ctrl_gated.iord;
    assign bus.EnR        = ctrl_gated.enr;
    assign bus.EnW        = ctrl_gated.enw;
    assign bus.BR_En      = ctrl_gated.br_en;
    assign bus.regDest    = ctrl_gated.reg_dest;
    assign bus.Mux1       = ctrl_gated.mux1;
    assign bus.AluSrcA    = ctrl_gated.alu_src_a;
    assign bus.AluSrcB    = ctrl_gated.alu_src_b;
    assign bus.AluC       = ctrl_gated.alu_c;
    assign bus.PCSrc      = ctrl_gated.pc_src;
    assign bus.Instr_Done = ctrl_gated.instr_done;
    assign bus.Illegal    = illegal & ~rst;
    assign bus.State      = rst ? 4'd0 : state;

endmodule
`default_nettype wire

// File: tb/tb_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_multiciclo
//  Purpose  : Directed self-checking bench for control_multiciclo.
//  Revision : 1.0  initial release
// ============================================================================
module tb_control_multiciclo;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    control_multiciclo_if bus ();

    control_multiciclo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Observed control word:
    // PC_En IR_En IorD EnR EnW BR_En regDest Mux1 AluSrcA AluSrcB[2] AluC[3] PCSrc Instr_Done
    logic [15:0] outs;
    assign outs = {bus.PC_En, bus.IR_En, bus.IorD, bus.EnR, bus.EnW, bus.BR_En,
                   bus.regDest, bus.Mux1, bus.AluSrcA, bus.AluSrcB, bus.AluC,
                   bus.PCSrc, bus.Instr_Done};

    // Hand-written expected control words
    localparam logic [15:0] V_ZERO      = 16'b0_0_0_0_0_0_0_0_0_00_000_0_0;
    localparam logic [15:0] V_FETCH_RDY = 16'b1_1_0_1_0_0_0_0_0_01_000_0_0;
    localparam logic [15:0] V_FETCH_WT  = 16'b0_0_0_1_0_0_0_0_0_01_000_0_0;
    localparam logic [15:0] V_DECODE    = 16'b0_0_0_0_0_0_0_0_0_11_000_0_0;
    localparam logic [15:0] V_DECODE_IL = 16'b0_0_0_0_0_0_0_0_0_11_000_0_1;
    localparam logic [15:0] V_MEM_ADDR  = 16'b0_0_0_0_0_0_0_0_1_10_000_0_0;
    localparam logic [15:0] V_MEM_READ  = 16'b0_0_1_1_0_0_0_0_0_00_000_0_0;
    localparam logic [15:0] V_MEM_WB    = 16'b0_0_0_0_0_1_0_1_0_00_000_0_1;
    localparam logic [15:0] V_MEM_WR_RD = 16'b0_0_1_0_1_0_0_0_0_00_000_0_1;
    localparam logic [15:0] V_MEM_WR_WT = 16'b0_0_1_0_1_0_0_0_0_00_000_0_0;
    localparam logic [15:0] V_EXEC_R    = 16'b0_0_0_0_0_0_0_0_1_00_010_0_0;
    localparam logic [15:0] V_R_WB      = 16'b0_0_0_0_0_1_1_0_0_00_000_0_1;
    localparam logic [15:0] V_EXEC_I    = 16'b0_0_0_0_0_0_0_0_1_10_000_0_0;
    localparam logic [15:0] V_I_WB      = 16'b0_0_0_0_0_1_0_0_0_00_000_0_1;
    localparam logic [15:0] V_BR_TAKEN  = 16'b1_0_0_0_0_0_0_0_1_00_001_1_1;
    localparam logic [15:0] V_BR_NOT    = 16'b0_0_0_0_0_0_0_0_1_00_001_1_1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: settle, check state/outputs/Illegal, advance past the edge
    task automatic cycle(input string tag, input logic [3:0] st,
                         input logic [15:0] v, input logic ill);
        #1;
        chk({tag, ".state"}, {12'd0, bus.State}, {12'd0, st});
        chk({tag, ".outs"}, outs, v);
        chk({tag, ".illegal"}, {15'd0, bus.Illegal}, {15'd0, ill});
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.Opcode   = 6'b000000;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b0;

        // Reset held for two edges: everything at zero
        @(posedge clk); #1;
        cycle("rst0", 4'd0, V_ZERO, 1'b0);
        cycle("rst1", 4'd0, V_ZERO, 1'b0);

        // R-type: 0,1,6,7
        rst = 1'b0; bus.MemReady = 1'b1; bus.Opcode = 6'b000000;
        cycle("r.fetch", 4'd0, V_FETCH_RDY, 1'b0);
        cycle("r.dec",   4'd1, V_DECODE,    1'b0);
        cycle("r.exec",  4'd6, V_EXEC_R,    1'b0);
        cycle("r.wb",    4'd7, V_R_WB,      1'b0);

        // LW with three wait cycles in MEM_READ (8 cycles total)
        bus.Opcode = 6'b100011;
        cycle("lw.fetch", 4'd0, V_FETCH_RDY, 1'b0);
        cycle("lw.dec",   4'd1, V_DECODE,    1'b0);
        cycle("lw.addr",  4'd2, V_MEM_ADDR,  1'b0);
        bus.MemReady = 1'b0;
        cycle("lw.rd_w0", 4'd3, V_MEM_READ,  1'b0);
        cycle("lw.rd_w1", 4'd3, V_MEM_READ,  1'b0);
        cycle("lw.rd_w2", 4'd3, V_MEM_READ,  1'b0);
        bus.MemReady = 1'b1;
        cycle("lw.rd",    4'd3, V_MEM_READ,  1'b0);
        cycle("lw.wb",    4'd4, V_MEM_WB,    1'b0);

        // SW, no wait (4 cycles)
        bus.Opcode = 6'b101011;
        cycle("sw.fetch", 4'd0, V_FETCH_RDY, 1'b0);
        cycle("sw.dec",   4'd1, V_DECODE,    1'b0);
        cycle("sw.addr",  4'd2, V_MEM_ADDR,  1'b0);
        cycle("sw.wr",    4'd5, V_MEM_WR_RD, 1'b0);

        // BEQ taken, with one fetch wait cycle first
        bus.Opcode = 6'b000100; bus.Zero = 1'b1; bus.MemReady = 1'b0;
        cycle("beq.fwait", 4'd0, V_FETCH_WT, 1'b0);
        bus.MemReady = 1'b1;
        cycle("beq.fetch", 4'd0, V_FETCH_RDY, 1'b0);
        cycle("beq.dec",   4'd1, V_DECODE,    1'b0);
        cycle("beq.take",  4'd10, V_BR_TAKEN, 1'b0);

        // BEQ not taken; MemReady low in DECODE must not stall
        bus.Zero = 1'b0;
        cycle("beqn.fetch", 4'd0, V_FETCH_RDY, 1'b0);
        bus.MemReady = 1'b0;
        cycle("beqn.dec",   4'd1, V_DECODE,    1'b0);
        bus.MemReady = 1'b1;
        cycle("beqn.br",    4'd10, V_BR_NOT,   1'b0);

        // Illegal opcode: 2 cycles, flag sets after DECODE
        bus.Opcode = 6'b111111;
        cycle("ill.fetch", 4'd0, V_FETCH_RDY, 1'b0);
        cycle("ill.dec",   4'd1, V_DECODE_IL, 1'b0);

        // ADDI afterwards; Illegal stays set
        bus.Opcode = 6'b001000;
        cycle("addi.fetch", 4'd0, V_FETCH_RDY, 1'b1);
        cycle("addi.dec",   4'd1, V_DECODE,    1'b1);
        cycle("addi.exec",  4'd8, V_EXEC_I,    1'b1);
        cycle("addi.wb",    4'd9, V_I_WB,      1'b1);

        // Reset in the middle of an LW read: immediate return, no writeback
        bus.Opcode = 6'b100011;
        cycle("lwr.fetch", 4'd0, V_FETCH_RDY, 1'b1);
        cycle("lwr.dec",   4'd1, V_DECODE,    1'b1);
        cycle("lwr.addr",  4'd2, V_MEM_ADDR,  1'b1);
        bus.MemReady = 1'b0;
        #1;
        chk("lwr.rd.state", {12'd0, bus.State}, 16'd3);
        rst = 1'b1; bus.MemReady = 1'b1;
        cycle("lwr.rst0", 4'd0, V_ZERO, 1'b0);
        cycle("lwr.rst1", 4'd0, V_ZERO, 1'b0);

        // SW with one write wait cycle after reset release
        rst = 1'b0; bus.Opcode = 6'b101011;
        cycle("sww.fetch", 4'd0, V_FETCH_RDY, 1'b0);
        cycle("sww.dec",   4'd1, V_DECODE,    1'b0);
        cycle("sww.addr",  4'd2, V_MEM_ADDR,  1'b0);
        bus.MemReady = 1'b0;
        cycle("sww.wait",  4'd5, V_MEM_WR_WT, 1'b0);
        bus.MemReady = 1'b1;
        cycle("sww.wr",    4'd5, V_MEM_WR_RD, 1'b0);
        cycle("sww.end",   4'd0, V_FETCH_RDY, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
